rename_rrf_fl: RTL

//  Parametrised rename register file (RRF) with a circular free-list FIFO.
//  - Hands out up to ALLOC_W free physical tags per cycle to Decode.
//  - Takes WB_PORTS writebacks from Execute and serves RD_PORTS tag reads with same-cycle bypass.
//  - Retires COMMIT_W entries per cycle from the ROB into registered ARF write ports.
//  - Recycles committed tags via the free list; replaces the first-free priority scan.

---
 rtl/rename_rrf_fl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/rename_rrf_fl.sv
// Rename register file with a circular free-list FIFO.
// Hands out ALLOC_W free tags per cycle, accepts writebacks with same-cycle
// read bypass, retires COMMIT_W tags into registered ARF write ports and
// recycles retired tags at the free-list tail.
module rename_rrf_fl #(
  parameter int NUM_PREGS = 128,
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 7,
  parameter int ALLOC_W   = 2,
  parameter int WB_PORTS  = 3,
  parameter int COMMIT_W  = 2,
  parameter int RD_PORTS  = 7,
  parameter int AREG_W    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [ALLOC_W-1:0]           alloc_req,
  output logic                         alloc_ready,
  output logic [ALLOC_W*TAG_W-1:0]     alloc_tag,
  input  logic [WB_PORTS-1:0]          wb_en,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
  input  logic [RD_PORTS*TAG_W-1:0]    rd_tag,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_valid,
  input  logic [COMMIT_W-1:0]          cm_en,
  input  logic [COMMIT_W*TAG_W-1:0]    cm_tag,
  input  logic [COMMIT_W*AREG_W-1:0]   cm_areg,
  output logic [COMMIT_W-1:0]          arf_wr_en,
  output logic [COMMIT_W*AREG_W-1:0]   arf_wr_idx,
  output logic [COMMIT_W*DATA_W-1:0]   arf_wr_data,
  output logic [TAG_W:0]               free_count,
  output logic                         err_bad_commit
);

  localparam int CNT_W = TAG_W + 1;

  // Physical register state and the free list
  logic [NUM_PREGS-1:0]   r_busy;
  logic [NUM_PREGS-1:0]   r_valid;
  logic [DATA_W-1:0]      r_data [NUM_PREGS];
  logic [TAG_W-1:0]       r_fifo [NUM_PREGS];
  logic [TAG_W-1:0]       r_head;
  logic [TAG_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_free_count;

  // Registered ARF write ports and error pulse
  logic [COMMIT_W-1:0]        r_arf_wr_en;
  logic [COMMIT_W*AREG_W-1:0] r_arf_wr_idx;
  logic [COMMIT_W*DATA_W-1:0] r_arf_wr_data;
  logic                       r_err;

  // Unpacked views of the flattened port buses
  logic [TAG_W-1:0]  w_wb_tag    [WB_PORTS];
  logic [DATA_W-1:0] w_wb_data   [WB_PORTS];
  logic [TAG_W-1:0]  w_rd_tag    [RD_PORTS];
  logic [DATA_W-1:0] w_rd_data   [RD_PORTS];
  logic [RD_PORTS-1:0] w_rd_valid;
  logic [TAG_W-1:0]  w_alloc_tag [ALLOC_W];
  logic [TAG_W-1:0]  w_cm_tag    [COMMIT_W];
  logic [AREG_W-1:0] w_cm_areg   [COMMIT_W];
  logic [DATA_W-1:0] w_cm_data   [COMMIT_W];
  logic [TAG_W-1:0]  w_push_off  [COMMIT_W];
  logic [COMMIT_W-1:0] w_cm_hit;
  logic [COMMIT_W-1:0] w_cm_legal;
  logic [CNT_W-1:0]  w_n_push;
  logic [CNT_W-1:0]  w_n_pop;
  logic [CNT_W-1:0]  w_pop;
  logic              w_grant;

  genvar gi;
  generate
    for (gi = 0; gi < WB_PORTS; gi++) begin : g_wb
      assign w_wb_tag[gi]  = wb_tag[gi*TAG_W +: TAG_W];
      assign w_wb_data[gi] = wb_data[gi*DATA_W +: DATA_W];
    end
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      assign w_rd_tag[gi]                  = rd_tag[gi*TAG_W +: TAG_W];
      assign rd_data[gi*DATA_W +: DATA_W]  = w_rd_data[gi];
    end
    for (gi = 0; gi < ALLOC_W; gi++) begin : g_alloc
      // Pointer arithmetic wraps naturally because NUM_PREGS == 2**TAG_W
      assign w_alloc_tag[gi]               = r_fifo[r_head + TAG_W'(gi)];
      assign alloc_tag[gi*TAG_W +: TAG_W]  = w_alloc_tag[gi];
    end
    for (gi = 0; gi < COMMIT_W; gi++) begin : g_cm
      assign w_cm_tag[gi]  = cm_tag[gi*TAG_W +: TAG_W];
      assign w_cm_areg[gi] = cm_areg[gi*AREG_W +: AREG_W];
    end
  endgenerate

  assign rd_valid       = w_rd_valid;
  assign alloc_ready    = (r_free_count >= CNT_W'(ALLOC_W));
  assign free_count     = r_free_count;
  assign arf_wr_en      = r_arf_wr_en;
  assign arf_wr_idx     = r_arf_wr_idx;
  assign arf_wr_data    = r_arf_wr_data;
  assign err_bad_commit = r_err;

  // Read ports: array contents, overridden by a same-cycle writeback (highest port wins)
  always_comb begin
    w_rd_valid = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      w_rd_data[r]  = r_data[w_rd_tag[r]];
      w_rd_valid[r] = r_valid[w_rd_tag[r]];
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_en[p] && (w_wb_tag[p] == w_rd_tag[r])) begin
          w_rd_data[r]  = w_wb_data[p];
          w_rd_valid[r] = 1'b1;
        end
      end
    end
  end

  // Commit legality, bypassed commit data and compacted push offsets
  always_comb begin
    w_cm_hit   = '0;
    w_cm_legal = '0;
    w_n_push   = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      w_cm_data[j]  = r_data[w_cm_tag[j]];
      w_push_off[j] = w_n_push[TAG_W-1:0];
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_en[p] && (w_wb_tag[p] == w_cm_tag[j])) begin
          w_cm_data[j] = w_wb_data[p];
          w_cm_hit[j]  = 1'b1;
        end
      end
      w_cm_legal[j] = cm_en[j] & r_busy[w_cm_tag[j]]
                    & (r_valid[w_cm_tag[j]] | w_cm_hit[j]);
      // An earlier lane retiring the same tag owns it; later duplicates are errors
      for (int i = 0; i < COMMIT_W; i++) begin
        if ((i < j) && cm_en[i] && (w_cm_tag[i] == w_cm_tag[j])) begin
          w_cm_legal[j] = 1'b0;
        end
      end
      if (w_cm_legal[j]) begin
        w_n_push = w_n_push + CNT_W'(1);
      end
    end
  end

  // Allocation: all-or-nothing grant gated by alloc_ready
  always_comb begin
    w_n_pop = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      if (alloc_req[k]) begin
        w_n_pop = w_n_pop + CNT_W'(1);
      end
    end
    w_grant = alloc_ready & (|alloc_req);
    w_pop   = w_grant ? w_n_pop : '0;
  end

  // State update: reset > flush > stall > writeback/alloc/commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy        <= '0;
      r_valid       <= '0;
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_data[i] <= '0;
        r_fifo[i] <= TAG_W'(i);
      end
      r_head        <= '0;
      r_tail        <= '0;
      r_free_count  <= CNT_W'(NUM_PREGS);
      r_arf_wr_en   <= '0;
      r_arf_wr_idx  <= '0;
      r_arf_wr_data <= '0;
      r_err         <= 1'b0;
    end else if (flush) begin
      r_busy        <= '0;
      r_valid       <= '0;
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_data[i] <= '0;
        r_fifo[i] <= TAG_W'(i);
      end
      r_head        <= '0;
      r_tail        <= '0;
      r_free_count  <= CNT_W'(NUM_PREGS);
      r_arf_wr_en   <= '0;
      r_arf_wr_idx  <= '0;
      r_arf_wr_data <= '0;
      r_err         <= 1'b0;
    end else if (stall) begin
      r_arf_wr_en <= '0;
      r_err       <= 1'b0;
    end else begin
      // Writebacks land only on busy tags; later ports overwrite earlier ones
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_en[p] && r_busy[w_wb_tag[p]]) begin
          r_data[w_wb_tag[p]]  <= w_wb_data[p];
          r_valid[w_wb_tag[p]] <= 1'b1;
        end
      end
      // Allocated tags come from the free list, so they never collide with writebacks
      if (w_grant) begin
        for (int k = 0; k < ALLOC_W; k++) begin
          if (alloc_req[k]) begin
            r_busy[w_alloc_tag[k]]  <= 1'b1;
            r_valid[w_alloc_tag[k]] <= 1'b0;
          end
        end
      end
      // Commit is applied last so it overrides a writeback to the retiring tag
      for (int j = 0; j < COMMIT_W; j++) begin
        if (w_cm_legal[j]) begin
          r_busy[w_cm_tag[j]]               <= 1'b0;
          r_valid[w_cm_tag[j]]              <= 1'b0;
          r_fifo[r_tail + w_push_off[j]]    <= w_cm_tag[j];
          r_arf_wr_idx[j*AREG_W +: AREG_W]  <= w_cm_areg[j];
          r_arf_wr_data[j*DATA_W +: DATA_W] <= w_cm_data[j];
        end else begin
          r_arf_wr_idx[j*AREG_W +: AREG_W]  <= '0;
          r_arf_wr_data[j*DATA_W +: DATA_W] <= '0;
        end
      end
      r_arf_wr_en  <= w_cm_legal;
      r_err        <= |(cm_en & ~w_cm_legal);
      r_head       <= r_head + w_pop[TAG_W-1:0];
      r_tail       <= r_tail + w_n_push[TAG_W-1:0];
      r_free_count <= r_free_count + w_n_push - w_pop;
    end
  end

endmodule
